// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes
// and the datapath mux / ALU select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTER = 4'd7,
    S_EXECUTEI = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11,
    S_JAL      = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode: aluOp plus funct fields to aluControl, flagging
// funct3 values this core does not implement.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control,
  output logic       bad_funct3
);

  always_comb begin
    alu_control = ALU_ADD;
    bad_funct3  = 1'b0;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // sub only for R-type with funct7b5; addi ignores bit 30
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: bad_funct3  = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I core; outputs decode from the
// state register, illegal is a sticky flag cleared only by reset.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int RESET_TO_IDLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] immSrc,
  output logic       regWrite,
  output logic [2:0] aluControl,
  output logic       instrDone,
  output logic       illegal
);

  localparam state_t RST_STATE = (RESET_TO_IDLE != 0) ? S_IDLE : S_FETCH;

  state_t     state;
  logic       pc_update, branch, bad_funct3;
  logic [1:0] alu_op;

  alu_decoder u_alu_dec (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alu_control(aluControl),
    .bad_funct3 (bad_funct3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RST_STATE;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXECUTER;
            OP_I:         state <= S_EXECUTEI;
            OP_BEQ:       state <= S_BEQ;
            OP_JAL:       state <= S_JAL;
            default: begin
              state   <= S_HALT;
              illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR:  state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD: state <= S_MEMWB;
        S_EXECUTER, S_EXECUTEI: begin
          if (bad_funct3) begin
            state   <= S_HALT;
            illegal <= 1'b1;
          end else begin
            state <= S_ALUWB;
          end
        end
        S_JAL:  state <= S_ALUWB;
        S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state <= S_FETCH;
        default: state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    alu_op    = ALUOP_ADD;
    adrSrc    = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    resultSrc = RES_ALUOUT;
    aluSrcA   = SRCA_PC;
    aluSrcB   = SRCB_RS2;
    regWrite  = 1'b0;
    instrDone = 1'b0;
    case (state)
      S_FETCH: begin
        irWrite   = 1'b1;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALURES;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMREAD: adrSrc = 1'b1;
      S_MEMWB: begin
        resultSrc = RES_RDATA;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc    = 1'b1;
        memWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_EXECUTER: begin
        aluSrcA = SRCA_RS1;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_BEQ: begin
        aluSrcA   = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        instrDone = 1'b1;
      end
      S_JAL: begin
        aluSrcA   = SRCA_OLDPC;
        aluSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
    pcWrite = pc_update | (branch & zero);
    immSrc  = (state == S_IDLE || state == S_HALT) ? IMM_I : imm_src(op);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues the expected output
// vector for every cycle, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, instrDone, illegal;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0] aluControl;

  multicycle_ctrl #(.RESET_TO_IDLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite),
    .irWrite(irWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .immSrc(immSrc), .regWrite(regWrite),
    .aluControl(aluControl), .instrDone(instrDone), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [17:0] vec;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [17:0] act;
  localparam logic [17:0] HALT_V = 18'h00001;

  assign act = {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
                immSrc, regWrite, aluControl, instrDone, illegal};

  // field order: pcWrite adrSrc memWrite irWrite resultSrc aluSrcA aluSrcB immSrc regWrite aluControl instrDone illegal
  function automatic logic [17:0] v(input logic pcw, adr, mw, irw,
                                    input logic [1:0] rs, sa, sb, imm,
                                    input logic rw, input logic [2:0] alu,
                                    input logic done, ill);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu, done, ill};
  endfunction

  function automatic logic [17:0] fetch_v(input logic [1:0] imm);
    return v(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 0, 3'b000, 0, 0);
  endfunction

  function automatic logic [17:0] decode_v(input logic [1:0] imm);
    return v(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 0, 3'b000, 0, 0);
  endfunction

  task automatic chk(input string tag, input logic [17:0] a, input logic [17:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", tag, a, e);
    end
  endtask

  task automatic push(input string tag, input logic [17:0] vec);
    exp_t e;
    e.tag = tag;
    e.vec = vec;
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  // R-type: FETCH, DECODE, EXECUTER, ALUWB
  task automatic run_r(input string tag, input logic [2:0] f3, input logic f7,
                       input logic z, input logic [2:0] alu);
    set_in(7'b0110011, f3, f7, z);
    push({tag, ".f"}, fetch_v(2'b00));
    push({tag, ".d"}, decode_v(2'b00));
    push({tag, ".ex"}, v(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, alu, 0, 0));
    push({tag, ".wb"}, v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000, 1, 0));
    cyc(4);
  endtask

  task automatic run_beq(input string tag, input logic z);
    set_in(7'b1100011, 3'b000, 1'b0, z);
    push({tag, ".f"}, fetch_v(2'b10));
    push({tag, ".d"}, decode_v(2'b10));
    push({tag, ".br"}, v(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 3'b001, 1, 0));
    cyc(3);
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1 chk(tag, act, 18'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    push({tag, ".idle"}, 18'h0);
    cyc(1);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk(mon_e.tag, act, mon_e.vec);
    end
  end

  initial begin
    rst_n = 1'b0;
    set_in(7'b0, 3'b0, 1'b0, 1'b0);
    #3 chk("reset_outputs", act, 18'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    push("idle0", 18'h0);
    cyc(1);

    // lw: 5 cycles
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
    push("lw.f", fetch_v(2'b00));
    push("lw.d", decode_v(2'b00));
    push("lw.adr", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000, 0, 0));
    push("lw.rd", v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0, 0));
    push("lw.wb", v(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 3'b000, 1, 0));
    cyc(5);

    // sw: 4 cycles
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
    push("sw.f", fetch_v(2'b01));
    push("sw.d", decode_v(2'b01));
    push("sw.adr", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 0, 3'b000, 0, 0));
    push("sw.mw", v(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 3'b000, 1, 0));
    cyc(4);

    // zero held high through an R-type must not move the PC outside FETCH
    run_r("sub", 3'b000, 1'b1, 1'b1, 3'b001);
    run_r("add", 3'b000, 1'b0, 1'b0, 3'b000);
    run_r("or",  3'b110, 1'b0, 1'b0, 3'b011);
    run_r("and", 3'b111, 1'b0, 1'b0, 3'b010);
    run_r("slt", 3'b010, 1'b0, 1'b0, 3'b101);

    // addi with bit30 set still adds
    set_in(7'b0010011, 3'b000, 1'b1, 1'b0);
    push("addi.f", fetch_v(2'b00));
    push("addi.d", decode_v(2'b00));
    push("addi.ex", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000, 0, 0));
    push("addi.wb", v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000, 1, 0));
    cyc(4);

    run_beq("beq_t", 1'b1);
    run_beq("beq_nt", 1'b0);

    set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
    push("jal.f", fetch_v(2'b11));
    push("jal.d", decode_v(2'b11));
    push("jal.j", v(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 0, 3'b000, 0, 0));
    push("jal.wb", v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 1, 3'b000, 1, 0));
    cyc(4);

    // reset asserted in the middle of MEMWRITE
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
    push("swr.f", fetch_v(2'b01));
    push("swr.d", decode_v(2'b01));
    push("swr.adr", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 0, 3'b000, 0, 0));
    cyc(3);
    #1 chk("swr.mw_live", act, v(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 3'b000, 1, 0));
    reset_pulse("rst_mid_sw");
    run_r("post_rst", 3'b000, 1'b0, 1'b0, 3'b000);

    // lui is unsupported: halt after DECODE
    set_in(7'b0110111, 3'b000, 1'b0, 1'b0);
    push("lui.f", fetch_v(2'b00));
    push("lui.d", decode_v(2'b00));
    repeat (12) push("lui.halt", HALT_V);
    cyc(14);
    reset_pulse("rst_clr_lui");

    // R-type funct3=001 is unsupported: halt after EXECUTER
    set_in(7'b0110011, 3'b001, 1'b0, 1'b0);
    push("r001.f", fetch_v(2'b00));
    push("r001.d", decode_v(2'b00));
    push("r001.ex", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b000, 0, 0));
    repeat (10) push("r001.halt", HALT_V);
    cyc(13);
    reset_pulse("rst_clr_r001");
    run_r("post_halt", 3'b111, 1'b0, 1'b0, 3'b010);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control unit for the multicycle RV32I core. A Moore state machine sequences one instruction over 3–5 cycles through fetch, decode, execute, memory and writeback. It drives the datapath muxes, write enables and ALU control. It also drives the 2-bit `immSrc` select consumed by the sign-extension unit (00 I, 01 S, 10 B, 11 J). Unsupported opcodes halt the core.

Parameters:
- RESET_TO_IDLE, 1, when 1 the FSM enters IDLE on reset and spends one cycle there before FETCH; when 0 it enters FETCH directly.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- pcWrite  out  1  PC register enable.
- adrSrc  out  1  memory address select: 0 PC, 1 aluOut.
- memWrite  out  1  data memory write enable.
- irWrite  out  1  instruction register and oldPC enable.
- resultSrc  out  2  result select: 00 aluOut, 01 readData, 10 aluResult.
- aluSrcA  out  2  ALU A select: 00 PC, 01 oldPC, 10 rs1.
- aluSrcB  out  2  ALU B select: 00 rs2, 01 immExt, 10 constant 4.
- immSrc  out  2  sign-extension format select.
- regWrite  out  1  register file write enable.
- aluControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- instrDone  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal  out  1  sticky: unsupported opcode or funct3 was decoded.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE (FETCH if RESET_TO_IDLE=0) and illegal clears.
  - In IDLE all outputs are 0, including immSrc=00 and aluControl=000.
  - Reset mid-instruction aborts it immediately; no write enable stays high after rst_n falls.
- Outputs:
  - Combinational from the state register.
  - pcWrite = pcUpdate | (branch & zero).
  - Any signal not listed for a state is 0.
- States and transitions:
  - IDLE → FETCH.
  - FETCH: adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10, pcUpdate=1 → DECODE.
  - DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (branch-target precompute). Next state by op:
    - lw 0000011 or sw 0100011 → MEMADR.
    - R 0110011 → EXECUTER.
    - I-ALU 0010011 → EXECUTEI.
    - beq 1100011 → BEQ.
    - jal 1101111 → JAL.
    - anything else → HALT, set illegal.
  - MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00 → MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: resultSrc=00, adrSrc=1 → MEMWB.
  - MEMWB: resultSrc=01, regWrite=1, instrDone=1 → FETCH.
  - MEMWRITE: resultSrc=00, adrSrc=1, memWrite=1, instrDone=1 → FETCH.
  - EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10 → ALUWB.
  - EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10 → ALUWB.
  - ALUWB: resultSrc=00, regWrite=1, instrDone=1 → FETCH.
  - BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1, instrDone=1 → FETCH.
  - JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1 → ALUWB.
  - HALT: all outputs 0, illegal=1; stays until reset.
- Cycles per instruction: lw 5, sw 4, R 4, I-ALU 4, jal 4, beq 3.
- immSrc is decoded combinationally from op in every state except IDLE and HALT (which force 00):
  - lw and I-ALU → 00.
  - sw → 01.
  - beq → 10.
  - jal → 11.
  - R-type and unsupported opcodes → 00.
- ALU decode:
  - aluOp 00 → add; aluOp 01 → sub.
  - aluOp 10 decodes funct3:
    - 000 → sub when op[5]&funct7b5, else add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.
    - any other funct3 → add, set illegal, and go to HALT instead of ALUWB.
- Simultaneous events: rst_n low overrides every transition; zero is sampled only in BEQ.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum (4-bit encoding, IDLE=0 … HALT=11);
  - opcode constants;
  - aluOp, aluControl, resultSrc, aluSrcA/B and immSrc encodings.
- Sub-module alu_decoder: combinational aluOp/funct3/funct7b5/op[5] → aluControl plus a bad-funct3 flag.
- Everything else lives in multicycle_ctrl.

Test Plan:
- Reset: rst_n=0 mid-MEMWRITE → memWrite drops asynchronously and state goes to IDLE; after release, IDLE lasts 1 cycle, then FETCH with irWrite=1, pcWrite=1.
- lw (op 0000011): FETCH, DECODE, MEMADR, MEMREAD, MEMWB → 5 cycles, regWrite=1 only in cycle 5, resultSrc=01 there, immSrc=00, instrDone pulses once.
- sw (op 0100011): 4 cycles, immSrc=01, memWrite=1 and adrSrc=1 in cycle 4 only, regWrite never set.
- beq with zero=1 vs zero=0: pcWrite=1 vs 0 in cycle 3, aluControl=001, immSrc=10; jal: immSrc=11, pcWrite=1 in JAL, regWrite in ALUWB, 4 cycles.
- R-type sub (funct3=000, funct7b5=1) → aluControl=001; addi (op 0010011, funct7b5=1) → aluControl=000; or → 011; and → 010; slt → 101.
- Illegal: op=0110111 (lui) → HALT after DECODE, illegal=1, all enables 0 for 10+ cycles; R-type funct3=001 → HALT; only rst_n clears illegal.
